// File: rtl/spi_master_mode.sv
// Full-duplex SPI master with run-time CPOL/CPHA, programmable SCLK half-period
// and one-hot active-low chip selects; start/busy/done handshake toward the host.
module spi_master_mode #(
    parameter int DWIDTH = 8,
    parameter int NCS    = 4,
    parameter int DIVW   = 8,
    parameter int CSW    = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CSW-1:0]    cs_idx,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIVW-1:0]   div,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout,
    output logic              busy,
    output logic              done,
    input  logic              miso,
    output logic              mosi,
    output logic              sclk,
    output logic [NCS-1:0]    cs_n
);

    localparam int ECW = $clog2(2 * DWIDTH + 1);
    localparam logic [ECW-1:0] LAST_EDGE = ECW'(2 * DWIDTH);
    localparam logic [ECW-1:0] EDGE_ONE  = ECW'(1);
    localparam logic [CSW:0]   NCS_LIM   = (CSW + 1)'(NCS);
    localparam logic [NCS-1:0] CS_ONE    = NCS'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]        state;
    logic [DIVW-1:0]   cnt;
    logic [DIVW-1:0]   div_q;
    logic              cpol_q;
    logic              cpha_q;
    logic [ECW-1:0]    edge_cnt;
    logic [DWIDTH-1:0] tx_sh;
    logic [DWIDTH-1:0] rx_sh;

    logic              accept;
    logic              cnt_zero;
    logic              fire_edge;
    logic [ECW-1:0]    edge_nxt;
    logic              sample_edge;
    logic              shift_edge;

    always_comb begin
        accept    = start && (state == S_IDLE) && ({1'b0, cs_idx} < NCS_LIM);
        cnt_zero  = (cnt == '0);
        // The SETUP->XFER step produces edge 1; every later half-period boundary
        // inside XFER produces the next edge until all 2*DWIDTH have been issued.
        fire_edge = cnt_zero && ((state == S_SETUP) ||
                                 ((state == S_XFER) && (edge_cnt != LAST_EDGE)));
        edge_nxt  = (state == S_SETUP) ? EDGE_ONE : edge_cnt + EDGE_ONE;
        sample_edge = cpha_q ? ~edge_nxt[0] : edge_nxt[0];
        shift_edge  = cpha_q ? (edge_nxt[0] && (edge_nxt != EDGE_ONE))
                             : (~edge_nxt[0] && (edge_nxt != LAST_EDGE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            div_q    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            edge_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            dout     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mosi     <= 1'b0;
            sclk     <= 1'b0;
            cs_n     <= '1;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    sclk <= cpol;
                    if (accept) begin
                        state    <= S_SETUP;
                        busy     <= 1'b1;
                        cnt      <= div;
                        div_q    <= div;
                        cpol_q   <= cpol;
                        cpha_q   <= cpha;
                        cs_n     <= ~(CS_ONE << cs_idx);
                        tx_sh    <= din;
                        mosi     <= din[DWIDTH-1];
                        rx_sh    <= '0;
                        edge_cnt <= '0;
                    end
                end
                S_SETUP: begin
                    if (cnt_zero) begin
                        state <= S_XFER;
                        cnt   <= div_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_XFER: begin
                    if (cnt_zero) begin
                        cnt <= div_q;
                        if (edge_cnt == LAST_EDGE) begin
                            state <= S_HOLD;
                            sclk  <= cpol_q;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt_zero) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cs_n  <= '1;
                        dout  <= rx_sh;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (fire_edge) begin
                sclk     <= ~sclk;
                edge_cnt <= edge_nxt;
                if (sample_edge) begin
                    rx_sh <= {rx_sh[DWIDTH-2:0], miso};
                end
                if (shift_edge) begin
                    tx_sh <= tx_sh << 1;
                    mosi  <= tx_sh[DWIDTH-2];
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master_mode.sv
// Bench for spi_master_mode: a slave model driven by observed SCLK edges checks
// mosi bits, sample-edge polarity, chip selects, latency and the received word.
module tb_spi_master_mode;

    localparam int D    = 8;
    localparam int NCS  = 5;
    localparam int DIVW = 8;
    localparam int CSW  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [CSW-1:0]  cs_idx;
    logic            cpol;
    logic            cpha;
    logic [DIVW-1:0] div;
    logic [D-1:0]    din;
    logic [D-1:0]    dout;
    logic            busy;
    logic            done;
    logic            miso;
    logic            mosi;
    logic            sclk;
    logic [NCS-1:0]  cs_n;

    spi_master_mode #(.DWIDTH(D), .NCS(NCS), .DIVW(DIVW)) dut (
        .clk(clk), .rst(rst), .start(start), .cs_idx(cs_idx), .cpol(cpol),
        .cpha(cpha), .div(div), .din(din), .dout(dout), .busy(busy), .done(done),
        .miso(miso), .mosi(mosi), .sclk(sclk), .cs_n(cs_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model of the transfer in flight
    logic           m_cpol = 1'b0;
    logic           m_cpha = 1'b0;
    logic [D-1:0]   m_sw   = '0;
    logic [D-1:0]   m_din  = '0;
    int             m_div  = 0;
    logic [NCS-1:0] exp_csn = '1;
    logic [D-1:0]   last_dout = '0;
    int             ek = 0;
    logic [D-1:0]   rx_mosi = '0;
    int             lvl_err = 0;
    int             cs_err = 0;
    logic           prev_busy = 1'b0;
    logic           prev_sclk = 1'b0;
    logic           hold_sclk = 1'b0;

    // slave: counts SCLK edges while selected, captures mosi on sample edges,
    // presents the next reply bit on the opposite edges
    always @(negedge clk) begin
        if (busy) begin
            if (cs_n != exp_csn) cs_err++;
            if (prev_busy && sclk != prev_sclk) begin
                ek++;
                if (m_cpha ? (ek % 2 == 0) : (ek % 2 == 1)) begin
                    rx_mosi = {rx_mosi[D-2:0], mosi};
                    if (sclk != (m_cpha ? m_cpol : ~m_cpol)) lvl_err++;
                end else if (m_cpha) begin
                    miso = m_sw[D-1-(ek-1)/2];
                end else if (ek < 2 * D) begin
                    miso = m_sw[D-1-ek/2];
                end
            end
            hold_sclk = sclk;
        end else if (cs_n != '1) begin
            cs_err++;
        end
        prev_busy = busy;
        prev_sclk = sclk;
    end

    task automatic arm(input logic [D-1:0] d, input logic [D-1:0] sw, input logic pol,
                       input logic pha, input int dv, input int cs);
        m_cpol  = pol;
        m_cpha  = pha;
        m_sw    = sw;
        m_din   = d;
        m_div   = dv;
        exp_csn = '1;
        exp_csn[cs] = 1'b0;
        ek      = 0;
        rx_mosi = '0;
        lvl_err = 0;
        cs_err  = 0;
        miso    = pha ? 1'b0 : sw[D-1];
        cpol    = pol;
        cpha    = pha;
        din     = d;
        div     = DIVW'(dv);
        cs_idx  = CSW'(cs);
    endtask

    task automatic wait_done(output int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        d = cyc;
        if (!ok) chk("done_timeout", 32'd0, 32'd1);
    endtask

    // called at the negedge where done is seen; returns one negedge later
    task automatic check_done(input string tag, input int s, input int d);
        chk({tag, "_latency"}, d - s, 1 + (2 * D + 2) * (m_div + 1));
        chk({tag, "_dout"}, dout, m_sw);
        chk({tag, "_mosi_word"}, rx_mosi, m_din);
        chk({tag, "_edges"}, ek, 2 * D);
        chk({tag, "_sample_level"}, lvl_err, 0);
        chk({tag, "_cs"}, cs_err, 0);
        chk({tag, "_hold_sclk"}, hold_sclk, m_cpol);
        chk({tag, "_busy_at_done"}, busy, 1'b0);
        chk({tag, "_csn_at_done"}, cs_n, {NCS{1'b1}});
        last_dout = m_sw;
        @(negedge clk);
        chk({tag, "_done_width"}, done, 1'b0);
    endtask

    task automatic xfer(input string tag, input logic [D-1:0] d, input logic [D-1:0] sw,
                        input logic pol, input logic pha, input int dv, input int cs,
                        input bit scramble);
        int  s, dd;
        bit  ok;
        arm(d, sw, pol, pha, dv, cs);
        repeat (2) @(negedge clk);
        chk({tag, "_idle_sclk"}, sclk, pol);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_rise"}, busy, 1'b1);
        if (scramble) begin
            cpol   = 1'($urandom);
            cpha   = 1'($urandom);
            div    = DIVW'($urandom);
            din    = D'($urandom);
            cs_idx = CSW'($urandom);
        end
        wait_done(dd, ok);
        if (ok) check_done(tag, s, dd);
    endtask

    initial begin
        int  s, d1, d2, hits;
        bit  ok;
        rst = 1'b1; start = 1'b0; cs_idx = '0; cpol = 1'b0; cpha = 1'b0;
        div = '0; din = '0; miso = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_csn", cs_n, {NCS{1'b1}});
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_dout", dout, 0);
        rst = 1'b0;
        @(negedge clk);

        xfer("mode0", 8'hA5, 8'h3C, 1'b0, 1'b0, 1, 2, 1'b1);
        xfer("mode1", 8'h81, 8'h7E, 1'b0, 1'b1, $urandom_range(0, 3), 0, 1'b1);
        xfer("mode2", 8'h81, 8'h7E, 1'b1, 1'b0, $urandom_range(0, 3), 1, 1'b1);
        xfer("mode3", 8'h81, 8'h7E, 1'b1, 1'b1, $urandom_range(0, 3), 4, 1'b1);
        xfer("div0", D'($urandom), D'($urandom), 1'b0, 1'b0, 0, 3, 1'b0);
        xfer("div255", D'($urandom), D'($urandom), 1'b1, 1'b1, 255, 1, 1'b0);

        // start held through a transfer and into its done cycle
        arm(8'h5A, 8'hC3, 1'b0, 1'b1, 2, 3);
        repeat (2) @(negedge clk);
        start = 1'b1;
        s = cyc;
        wait_done(d1, ok);
        if (ok) begin
            check_done("held", s, d1);
            arm(8'h5A, 8'hC3, 1'b0, 1'b1, 2, 3);
            start = 1'b0;
            chk("b2b_busy_restart", busy, 1'b1);
            chk("b2b_csn_restart", cs_n, exp_csn);
            wait_done(d2, ok);
            if (ok) check_done("b2b", d1, d2);
        end
        start = 1'b0;

        // out-of-range chip select must be ignored
        @(negedge clk);
        cs_idx = CSW'($urandom_range(NCS, 7));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy || done || cs_n != '1) hits++;
            @(negedge clk);
        end
        chk("badcs_activity", hits, 0);
        chk("badcs_dout", dout, last_dout);

        // abort by reset after the fifth SCLK edge
        xfer("zero_rx", D'($urandom), 8'h00, 1'b0, 1'b0, 1, 1, 1'b0);
        arm(8'hF0, 8'hFF, 1'b1, 1'b0, 2, 2);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (ek >= 5) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) chk("abort_edge_timeout", 32'd0, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_csn", cs_n, {NCS{1'b1}});
        chk("abort_sclk", sclk, 1'b0);
        chk("abort_busy", busy, 1'b0);
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) hits++;
        end
        chk("abort_no_done", hits, 0);
        chk("abort_dout", dout, 0);
        xfer("post_abort", D'($urandom), D'($urandom), 1'b0, 1'b1, 1, 0, 1'b0);

        for (int n = 0; n < 10; n++) begin
            xfer("rand", D'($urandom), D'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 5), $urandom_range(0, NCS - 1), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
